// File: rtl/cmp_search_pkg.sv
// Shared types and helpers for the comparator-driven binary-search controller.
package cmp_search_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_e;

  localparam int unsigned CMP_EQ = 0;
  localparam int unsigned CMP_LT = 1;
  localparam int unsigned CMP_GT = 2;

  // A well-formed comparator answer has exactly one of {gt,lt,eq} set.
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/cmp_search_ctrl.sv
// Binary-search initiator: drives operand B into an external comparator and
// converges on the unknown operand A from the returned {gt,lt,eq} answer.
module cmp_search_ctrl
  import cmp_search_pkg::*;
#(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        cmp_res,
  output logic [WIDTH-1:0]  probe,
  output logic              probe_valid,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  found,
  output logic [STEP_W-1:0] steps,
  output logic              error
);

  localparam int unsigned EW = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_V = {WIDTH{1'b1}};

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  lo_q, lo_d, hi_q, hi_d;
  logic [WIDTH-1:0]  probe_q, probe_d, found_q, found_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [EW-1:0]     nlo_c, nhi_c;
  logic              bad_c;

  // Floor midpoint in one extra bit so lo+hi never wraps.
  function automatic logic [WIDTH-1:0] midpoint(input logic [EW-1:0] a,
                                                input logic [EW-1:0] b);
    logic [EW-1:0] s;
    s = a + b;
    return WIDTH'(s >> 1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= MAX_V;
      probe_q <= '0;
      found_q <= '0;
      steps_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      probe_q <= probe_d;
      found_q <= found_d;
      steps_q <= steps_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    probe_d = probe_q;
    found_d = found_q;
    steps_d = steps_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    bad_c   = 1'b0;
    nlo_c   = {1'b0, probe_q} + EW'(1);
    nhi_c   = {1'b0, probe_q} - EW'(1);

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = PROBE;
          lo_d    = '0;
          hi_d    = MAX_V;
          steps_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          probe_d = midpoint('0, {1'b0, MAX_V});
        end
      end
      PROBE: begin
        steps_d = steps_q + STEP_W'(1);
        if (!is_onehot3(cmp_res)) begin
          bad_c = 1'b1;
        end else if (cmp_res[CMP_EQ]) begin
          state_d = DONE;
          found_d = probe_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (cmp_res[CMP_GT]) begin
          if (probe_q == MAX_V || nlo_c > {1'b0, hi_q}) begin
            bad_c = 1'b1;
          end else begin
            lo_d    = WIDTH'(nlo_c);
            probe_d = midpoint(nlo_c, {1'b0, hi_q});
          end
        end else if (cmp_res[CMP_LT]) begin
          if (probe_q == '0 || {1'b0, lo_q} > nhi_c) begin
            bad_c = 1'b1;
          end else begin
            hi_d    = WIDTH'(nhi_c);
            probe_d = midpoint({1'b0, lo_q}, nhi_c);
          end
        end
        // Any inconsistency aborts the search and keeps the previous result.
        if (bad_c) begin
          state_d = ERR;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign probe       = probe_q;
  assign probe_valid = busy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign steps       = steps_q;
  assign error       = error_q;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed bench: a 2-bit comparator answers the controller while a plain
// binary-search model predicts every cycle's outputs.
module tb_cmp_search_ctrl;

  localparam int unsigned WIDTH  = 2;
  localparam int unsigned STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst_n, start;
  logic [2:0]        cmp_res, cmp_ref, force_val;
  logic              force_en;
  logic [WIDTH-1:0]  a_val;
  logic [WIDTH-1:0]  probe, found;
  logic              probe_valid, busy, done, error;
  logic [STEP_W-1:0] steps;

  int n_cmp, n_bad;
  int exp_probe, exp_busy, exp_done, exp_found, exp_steps, exp_error;
  logic chk_en;
  int model_q[$];

  always #5 clk = ~clk;

  // Existing 2-bit comparator as responder; the bench may override its answer.
  assign cmp_ref = {a_val > probe, a_val < probe, a_val == probe};
  assign cmp_res = force_en ? force_val : cmp_ref;

  cmp_search_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmp_res(cmp_res),
    .probe(probe), .probe_valid(probe_valid), .busy(busy), .done(done),
    .found(found), .steps(steps), .error(error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Probe sequence of an ordinary binary search over 0..2^WIDTH-1.
  function automatic void build_model(input int a);
    int lo, hi, m;
    model_q.delete();
    lo = 0;
    hi = (1 << WIDTH) - 1;
    while (lo <= hi) begin
      m = (lo + hi) / 2;
      model_q.push_back(m);
      if (m == a) break;
      if (a > m) lo = m + 1;
      else       hi = m - 1;
    end
  endfunction

  task automatic set_reset_exp();
    exp_probe = 0; exp_busy = 0; exp_done = 0;
    exp_found = 0; exp_steps = 0; exp_error = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("probe",       32'(probe),       exp_probe);
      check("probe_valid", 32'(probe_valid), exp_busy);
      check("busy",        32'(busy),        exp_busy);
      check("done",        32'(done),        exp_done);
      check("found",       32'(found),       exp_found);
      check("steps",       32'(steps),       exp_steps);
      check("error",       32'(error),       exp_error);
    end
  end

  // Runs one search; bad_idx >= 0 replaces the answer at that probe with bad_val.
  task automatic search(input int a, input int bad_idx, input logic [2:0] bad_val);
    a_val = WIDTH'(a);
    build_model(a);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    exp_done = 0; exp_error = 0; exp_busy = 1;
    for (int i = 0; i < model_q.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      exp_probe = model_q[i];
      exp_steps = i;
      if (i == bad_idx) begin
        force_val = bad_val;
        force_en  = 1'b1;
        @(posedge clk); #1 force_en = 1'b0;
        exp_busy  = 0;
        exp_error = 1;
        exp_steps = i + 1;
        return;
      end
    end
    @(posedge clk); #1;
    exp_busy  = 0;
    exp_done  = 1;
    exp_found = a;
    exp_steps = model_q.size();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; force_en = 1'b0; force_val = 3'b000; a_val = '0;
    set_reset_exp();
    chk_en = 1'b1;

    build_model(3);
    check("model_len_a3", model_q.size(), 3);
    check("model_a3_last", model_q[2], 3);
    build_model(0);
    check("model_len_a0", model_q.size(), 2);
    check("model_a0_last", model_q[1], 0);
    build_model(1);
    check("model_len_a1", model_q.size(), 1);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    search(1, -1, 3'b000);
    check("a1_found", 32'(found), 1);
    check("a1_steps", 32'(steps), 1);
    search(3, -1, 3'b000);
    check("a3_found", 32'(found), 3);
    check("a3_steps", 32'(steps), 3);
    search(0, -1, 3'b000);
    check("a0_found", 32'(found), 0);
    check("a0_steps", 32'(steps), 2);

    for (int a = 0; a < 4; a++) begin
      search(a, -1, 3'b000);
      check("sweep_found", 32'(found), a);
      check("sweep_steps_le3", 32'(steps <= 4'd3), 1);
      check("sweep_no_error", 32'(error), 0);
    end

    search(3, 1, 3'b011);
    check("bad_onehot_error", 32'(error), 1);
    check("bad_onehot_done", 32'(done), 0);
    check("bad_onehot_busy", 32'(busy), 0);
    search(2, -1, 3'b000);
    check("recover_found", 32'(found), 2);
    check("recover_error", 32'(error), 0);

    search(0, 1, 3'b010);
    check("lt_at_zero_error", 32'(error), 1);
    search(3, 2, 3'b100);
    check("gt_at_max_error", 32'(error), 1);
    search(0, 1, 3'b100);
    check("lo_gt_hi_error", 32'(error), 1);
    search(1, -1, 3'b000);
    check("recover2_found", 32'(found), 1);

    a_val = 2'd3;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    exp_busy = 1; exp_done = 0; exp_error = 0; exp_probe = 1; exp_steps = 0;
    #2 rst_n = 1'b0;
    set_reset_exp();
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_probe", 32'(probe), 0);
    check("rst_found", 32'(found), 0);
    check("rst_probe_valid", 32'(probe_valid), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    search(3, -1, 3'b000);
    check("post_rst_found", 32'(found), 3);
    check("post_rst_steps", 32'(steps), 3);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp_search_ctrl.md
Name: cmp_search_ctrl

Overview:
- Sequential initiator that drives the operand-B side of an external magnitude comparator and reads back its {gt,lt,eq} result.
- Uses binary search to find the unknown operand A presented to that comparator.
- Sits in front of the existing combinational 2-bit comparator, so the pair forms a closed-loop value finder.
- Also serves as the stimulus/consumer side for comparator checks.

Parameters:
- WIDTH, 2, operand width in bits; legal range 1..8.
- STEP_W, 4, width of the step counter; must hold WIDTH+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a search; sampled only in IDLE, DONE or ERR.
- cmp_res  input  3  comparator result: [2]=A>B, [1]=A<B, [0]=A==B. Combinational from probe.
- probe  output  WIDTH  operand B driven to the comparator.
- probe_valid  output  1  high in cycles where cmp_res is sampled.
- busy  output  1  high while in PROBE.
- done  output  1  level; search ended with eq.
- found  output  WIDTH  value of A; valid when done=1.
- steps  output  STEP_W  number of comparisons used in the last search.
- error  output  1  level; inconsistent comparator response.

Behaviour:
- Clocking and reset:
  - Single clock domain, clk rising edge; rst_n asynchronous assert, synchronous deassert at top level.
  - Reset values: state=IDLE, probe=0, probe_valid=0, busy=0, done=0, found=0, steps=0, error=0.
  - Internal lo=0, hi=2^WIDTH-1.
- States:
  - IDLE -> PROBE on start.
  - PROBE -> PROBE on gt/lt.
  - PROBE -> DONE on eq.
  - PROBE -> ERR on a bad response.
  - DONE or ERR -> PROBE on start, otherwise hold.
- Entering PROBE from start:
  - lo=0, hi=2^WIDTH-1, steps=0; done and error clear.
  - probe=(lo+hi)>>1, computed in WIDTH+1 bits (floor midpoint).
- PROBE cycle:
  - probe and probe_valid are stable for the whole cycle.
  - cmp_res is sampled at the closing edge; exactly one comparison per cycle; steps increments on each sample.
  - eq: found<=probe, done<=1, go to DONE.
  - gt: lo<=probe+1, new probe=(probe+1+hi)>>1.
  - lt: hi<=probe-1, new probe=(lo+probe-1)>>1.
- Error conditions; each sets error=1, goes to ERR, and leaves found unchanged:
  - cmp_res not one-hot (000, 011, 101, 110, 111).
  - lt with probe=0.
  - gt with probe=2^WIDTH-1.
  - Next lo>hi.
- Latency and bounds:
  - First probe is visible in the cycle after start is sampled.
  - At most WIDTH+1 PROBE cycles.
  - done is asserted the cycle after the eq sample.
- Simultaneous events and reset:
  - start while busy is ignored.
  - start in DONE/ERR restarts immediately; done/error drop on the same edge.
  - rst_n low mid-search returns to reset values asynchronously; no partial result is retained.
- Outputs:
  - All outputs are registered.
  - busy=1 only in PROBE; probe_valid equals busy.
  - probe is held at its last value outside PROBE.

Decomposition:
- Package cmp_search_pkg:
  - state enum {IDLE, PROBE, DONE, ERR}.
  - Localparams for cmp_res bit indices CMP_EQ=0, CMP_LT=1, CMP_GT=2.
  - One-hot check function.
- No sub-module in the RTL; the FSM and midpoint datapath stay in one module.
- The bench instantiates the existing 2-bit comparator as the responder, with A driven by the bench.

Test Plan:
- WIDTH=2, A=2'b01, pulse start:
  - Expected: probe=1 in the first PROBE cycle; eq.
  - Then done=1, found=1, steps=1, error=0.
- WIDTH=2, A=2'b11:
  - Expected: probes 1, 2, 3 on consecutive cycles.
  - Then done=1, found=3, steps=3 (worst case WIDTH+1).
- WIDTH=2, A=2'b00:
  - Expected: probes 1, 0.
  - Then found=0, steps=2.
- Sweep all A in 0..3 back-to-back, restarting with start in DONE:
  - Expected: found==A each time; steps<=3; no error.
- Bench forces cmp_res=3'b011 at the second probe:
  - Expected: error=1, state ERR, done=0, busy=0.
  - A following start clears error and the search succeeds.
- Assert rst_n=0 mid-search (A=3, after first probe):
  - Expected: all outputs return to reset values immediately.
  - After release, a start gives found=3, steps=3.
